// File: rtl/btn_press_gen.sv
// Button front end: per-button synchronizer, counter debounce and rising-edge
// detect, followed by a one-press-at-a-time arbiter producing single-cycle pulses.
module btn_press_gen #(
    parameter int NUM_BTN   = 5,
    parameter int DB_CYCLES = 16,
    parameter int IDX_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               press_valid,
    output logic [IDX_W-1:0]   press_idx,
    output logic [NUM_BTN-1:0] press_onehot,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               busy
);

    localparam int                 CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [NUM_BTN-1:0] BTN_ONE = NUM_BTN'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;
    logic [NUM_BTN-1:0] stable_q;
    logic [NUM_BTN-1:0] stable_d;
    logic [NUM_BTN-1:0] stable_dly_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rise;

    state_t             state_q;
    state_t             state_d;
    logic               press_valid_q;
    logic               press_valid_d;
    logic [IDX_W-1:0]   press_idx_q;
    logic [IDX_W-1:0]   press_idx_d;
    logic [NUM_BTN-1:0] press_onehot_q;
    logic [NUM_BTN-1:0] press_onehot_d;
    logic               busy_q;
    logic               busy_d;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // Debounce next-state: a level is accepted only after DB_CYCLES unbroken mismatching samples.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Synchronizer, debounce state and the delayed copy used by the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '{default: '0};
        end else begin
            s1_q         <= btn_raw;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign rise = stable_q & ~stable_dly_q;

    // Lowest-index rising button wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end else begin
                win_found = win_found;
            end
        end
    end

    // Arbiter next-state and next registered outputs.
    always_comb begin
        state_d        = state_q;
        press_valid_d  = 1'b0;
        press_idx_d    = '0;
        press_onehot_d = '0;
        busy_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = HELD;
                    press_valid_d  = 1'b1;
                    press_idx_d    = win_idx;
                    press_onehot_d = BTN_ONE << win_idx;
                    busy_d         = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                // Rises seen here are intentionally discarded, not queued.
                if (stable_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = HELD;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            press_valid_q  <= 1'b0;
            press_idx_q    <= '0;
            press_onehot_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            press_valid_q  <= press_valid_d;
            press_idx_q    <= press_idx_d;
            press_onehot_q <= press_onehot_d;
            busy_q         <= busy_d;
        end
    end

    assign press_valid  = press_valid_q;
    assign press_idx    = press_idx_q;
    assign press_onehot = press_onehot_q;
    assign btn_level    = stable_q;
    assign busy         = busy_q;

endmodule
